// File: rtl/risc.sv
// risc: single-cycle RiSC-16 core with an 8-entry register file and a unified
// 64K-word instruction/data memory. One instruction retires per rising edge.
module risc (
   input logic clk,
   input logic reset
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_ADDI = 3'b001,
      OP_NAND = 3'b010,
      OP_LUI  = 3'b011,
      OP_SW   = 3'b100,
      OP_LW   = 3'b101,
      OP_BEQ  = 3'b110,
      OP_JALR = 3'b111
   } opcode_t;

   // Architectural state; names are fixed so benches can reach them.
   logic [15:0] pc;
   logic [15:0] rf [0:7];
   logic [15:0] m  [0:65535];

   logic [15:0] instr;
   opcode_t     op;
   logic [2:0]  ra;
   logic [2:0]  rb;
   logic [2:0]  rc;
   logic [15:0] simm;
   logic [15:0] ra_val;
   logic [15:0] rb_val;
   logic [15:0] rc_val;
   logic [15:0] mem_addr;
   logic [15:0] pc_inc;

   logic [15:0] pc_next;
   logic [15:0] wb_data;
   logic        rf_we;
   logic        mem_we;

   assign instr    = m[pc];
   assign op       = opcode_t'(instr[15:13]);
   assign ra       = instr[12:10];
   assign rb       = instr[9:7];
   assign rc       = instr[2:0];
   assign simm     = {{9{instr[6]}}, instr[6:0]};

   // r0 reads as zero no matter what the storage holds.
   assign ra_val   = (ra == 3'd0) ? '0 : rf[ra];
   assign rb_val   = (rb == 3'd0) ? '0 : rf[rb];
   assign rc_val   = (rc == 3'd0) ? '0 : rf[rc];

   assign mem_addr = rb_val + simm;
   assign pc_inc   = pc + 16'd1;

   // Decode/execute: next pc, writeback value and write enables.
   always_comb begin
      pc_next = pc_inc;
      wb_data = '0;
      rf_we   = 1'b0;
      mem_we  = 1'b0;
      case (op)
         OP_ADD: begin
            rf_we   = 1'b1;
            wb_data = rb_val + rc_val;
         end
         OP_ADDI: begin
            rf_we   = 1'b1;
            wb_data = rb_val + simm;
         end
         OP_NAND: begin
            rf_we   = 1'b1;
            wb_data = ~(rb_val & rc_val);
         end
         OP_LUI: begin
            rf_we   = 1'b1;
            wb_data = {instr[9:0], 6'b0};
         end
         OP_SW: begin
            mem_we  = 1'b1;
         end
         OP_LW: begin
            rf_we   = 1'b1;
            wb_data = m[mem_addr];
         end
         OP_BEQ: begin
            if (ra_val == rb_val) pc_next = pc_inc + simm;
         end
         OP_JALR: begin
            // rb_val is the pre-edge value, so rA==rB still jumps to the old rB.
            rf_we   = 1'b1;
            wb_data = pc_inc;
            pc_next = rb_val;
         end
         default: pc_next = pc_inc;
      endcase
   end

   // pc and register file update; reset clears both but not memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= '0;
         for (int unsigned i = 0; i < 8; i++) rf[i[2:0]] <= '0;
      end else begin
         pc <= pc_next;
         if (rf_we && ra != 3'd0) rf[ra] <= wb_data;
      end
   end

   // Memory write port; suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (!reset && mem_we) m[mem_addr] <= ra_val;
   end

endmodule

// File: tb/tb_risc.sv
// tb_risc: directed single-instruction vectors plus multi-cycle sequences.
module tb_risc;

   logic clk;
   logic reset;

   int unsigned n_checks;
   int unsigned n_fail;

   risc dut (
      .clk   (clk),
      .reset (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] pc_i;
      logic [15:0] instr;
      logic [15:0] r1;
      logic [15:0] r2;
      int unsigned chk_reg;
      logic [15:0] exp_reg;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      for (int k = 0; k < int'(n); k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic clear_regs();
      for (int r = 1; r < 8; r++) dut.rf[r] = '0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;

      vecs[0] = '{"addi_r0",   16'h0020, 16'h2007, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0021};
      vecs[1] = '{"beq_ne",    16'h0030, 16'hC505, 16'h0005, 16'hFFFF, 1, 16'h0005, 16'h0031};
      vecs[2] = '{"beq_eq",    16'h0030, 16'hC505, 16'h0007, 16'h0007, 1, 16'h0007, 16'h0036};
      vecs[3] = '{"beq_back",  16'h0000, 16'hC07E, 16'h0003, 16'h0000, 1, 16'h0003, 16'hFFFF};
      vecs[4] = '{"jalr",      16'h0003, 16'hFC80, 16'h0005, 16'h0000, 7, 16'h0004, 16'h0005};
      vecs[5] = '{"jalr_same", 16'h0040, 16'hE480, 16'h0100, 16'h0000, 1, 16'h0041, 16'h0100};
      vecs[6] = '{"add_wrap",  16'h0050, 16'h0C82, 16'h0005, 16'hFFFF, 3, 16'h0004, 16'h0051};
      vecs[7] = '{"pc_wrap",   16'hFFFF, 16'h2481, 16'h0005, 16'h0000, 1, 16'h0006, 16'h0000};
      vecs[8] = '{"lui",       16'h0058, 16'h77FF, 16'h0000, 16'h0000, 5, 16'hFFC0, 16'h0059};
      vecs[9] = '{"nand",      16'h005A, 16'h5081, 16'h0005, 16'h0000, 4, 16'hFFFA, 16'h005B};

      // Reset clears pc/rf, then the five-instruction program runs.
      @(negedge clk);
      dut.pc = 16'h1234;
      for (int r = 0; r < 8; r++) dut.rf[r] = 16'hA5A5;
      dut.m[0] = 16'h2405;
      dut.m[1] = 16'h287F;
      dut.m[2] = 16'h0C82;
      dut.m[3] = 16'h5081;
      dut.m[4] = 16'h77FF;
      step(1);
      check("reset_pc", dut.pc, 16'h0000);
      for (int r = 1; r < 8; r++) check($sformatf("reset_r%0d", r), dut.rf[r], 16'h0000);
      reset = 1'b0;
      step(5);
      check("prog_r1", dut.rf[1], 16'h0005);
      check("prog_r2", dut.rf[2], 16'hFFFF);
      check("prog_r3", dut.rf[3], 16'h0004);
      check("prog_r4", dut.rf[4], 16'hFFFA);
      check("prog_r5", dut.rf[5], 16'hFFC0);
      check("prog_pc", dut.pc,    16'h0005);

      // Table of single-instruction vectors.
      for (int v = 0; v < 10; v++) begin
         clear_regs();
         dut.rf[1] = vecs[v].r1;
         dut.rf[2] = vecs[v].r2;
         dut.pc    = vecs[v].pc_i;
         dut.m[vecs[v].pc_i] = vecs[v].instr;
         step(1);
         if (vecs[v].chk_reg == 0)
            check({vecs[v].name, "_reg"}, dut.rf[0], vecs[v].exp_reg);
         else
            check({vecs[v].name, "_reg"}, dut.rf[vecs[v].chk_reg], vecs[v].exp_reg);
         check({vecs[v].name, "_pc"}, dut.pc, vecs[v].exp_pc);
      end

      // SW then LW round trip through m[60].
      clear_regs();
      dut.rf[1]   = 16'h0005;
      dut.m[60]   = 16'h0000;
      dut.m[16'h0060] = 16'h843C;
      dut.m[16'h0061] = 16'hB83C;
      dut.pc      = 16'h0060;
      step(2);
      check("sw_mem", dut.m[60],  16'h0005);
      check("lw_r6",  dut.rf[6],  16'h0005);
      check("mem_pc", dut.pc,     16'h0062);

      // Halt idiom: branch to self.
      dut.m[16'h0010] = 16'hC07F;
      dut.pc = 16'h0010;
      for (int c = 0; c < 4; c++) begin
         step(1);
         check($sformatf("halt_pc%0d", c), dut.pc, 16'h0010);
      end

      // Self-modifying code: SW rewrites the very next instruction.
      clear_regs();
      dut.rf[1] = 16'h2C07;
      dut.rf[2] = 16'h0071;
      dut.m[16'h0070] = 16'h8500;
      dut.m[16'h0071] = 16'h0000;
      dut.pc = 16'h0070;
      step(2);
      check("smc_r3", dut.rf[3], 16'h0007);
      check("smc_pc", dut.pc,    16'h0072);

      // Reset asserted mid-loop: state clears, memory kept, restart at m[0].
      clear_regs();
      dut.m[60] = 16'h1234;
      dut.m[0]  = 16'h2481;
      dut.m[1]  = 16'hC07E;
      dut.pc    = 16'h0000;
      step(5);
      check("loop_r1", dut.rf[1], 16'h0003);
      check("loop_pc", dut.pc,    16'h0001);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("mid_reset_pc",  dut.pc, 16'h0000);
      for (int r = 1; r < 8; r++) check($sformatf("mid_reset_r%0d", r), dut.rf[r], 16'h0000);
      check("mid_reset_mem", dut.m[60], 16'h1234);
      step(1);
      check("restart_pc", dut.pc,    16'h0001);
      check("restart_r1", dut.rf[1], 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/risc.md
# risc

Single-cycle 16-bit RiSC-16 processor core with internal register file and unified 64K-word instruction/data memory. It executes one instruction per rising clock edge: fetch, decode, execute, memory access and writeback all complete within that cycle. It is the top-level compute block of the design. Benches observe and preload its state hierarchically through `pc`, `rf` and `m`.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- One clock; reset is synchronous and active-high.
- No other ports.

Internal state, hierarchically accessible under these exact names:
- `pc`: 16-bit register, word address of the current instruction.
- `rf[0:7]`: 8 × 16-bit general registers.
- `m[0:65535]`: 16-bit words, word-addressed. Holds both program and data; a bench may preload it with `$readmemh`.

## Operation
- Instruction fields:
  - op = [15:13], rA = [12:10], rB = [9:7], rC = [2:0].
  - imm7 = [6:0], two's-complement, sign-extended to 16 bits.
  - imm10 = [9:0].
- Opcodes:
  - 000 ADD: rA ← rB + rC.
  - 001 ADDI: rA ← rB + sext(imm7).
  - 010 NAND: rA ← ~(rB & rC).
  - 011 LUI: rA ← {imm10, 6'b0}.
  - 100 SW: m[rB + sext(imm7)] ← rA.
  - 101 LW: rA ← m[rB + sext(imm7)].
  - 110 BEQ: if rA == rB then pc ← pc+1+sext(imm7), else pc ← pc+1.
  - 111 JALR: rA ← pc+1; pc ← rB. Bits [6:0] are ignored.
- All other opcodes: pc ← pc+1.
- Arithmetic, including address and branch computation, is modulo 2^16; carries are discarded. pc wraps 0xFFFF → 0x0000.
- r0 is hardwired to 0:
  - writes to rA=0 are discarded;
  - reads of r0 always return 0.
- JALR with rA=rB: the read uses the old rB value, then rA is written with pc+1.
- BEQ r0,r0,-1 (0xC07F) branches to itself. This is the halt idiom; no dedicated halt state.
- Reset (reset=1 at a rising edge):
  - pc ← 0 and rf[0..7] ← 0;
  - no instruction executes that cycle;
  - memory is not cleared.
- Reset takes priority over execution and may be asserted mid-program.

## Timing
- Instruction fetch `m[pc]`, register reads and LW data read are combinational, asynchronous reads.
- pc update, register write and memory write all occur on the same rising edge.
- Latency is exactly 1 cycle per instruction; there are no stalls and no hazards.
- A result written at edge N is visible to the instruction executing after edge N.
- A SW to the address of the next instruction (self-modifying code) takes effect for the fetch after that edge.
- If `pc`, `rf` or `m` are set hierarchically between edges, execution resumes from that state at the next edge.
- reset=0 with no prior reset: state is undefined until a bench initialises it.

## Test plan
- Reset, then run program 2405, 287F, 0C82, 5081, 77FF at m[0..4]:
  - after 5 edges: r1=0005, r2=FFFF, r3=0004 (wrap), r4=FFFA, r5=FFC0, pc=0005.
- Memory round-trip: with r1=5, run 843C then B83C:
  - m[60]=0005, r6=0005, pc advances by 2.
- r0 protection: execute 2007 (ADDI r0,r0,7) → r0 stays 0000.
- Branches:
  - 0xC07F at pc=0x10 → pc stays 0x10 for 3+ cycles.
  - BEQ with r1≠r2 falls through: pc → pc+1.
  - Backward offset −2 from pc=0 wraps pc to 0xFFFF.
- JALR: with r1=5 at pc=3, execute FC80 → r7=0004, pc=0005.
- Reset mid-run: assert reset for 1 edge during a loop:
  - pc=0 and all rf=0;
  - m contents (e.g. m[60]) unchanged;
  - execution restarts at m[0].
